// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types: sequencer states, watchdog width and the major
// opcodes that decode and the hazard/bypass unit key off.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2
   } pipe_state_e;

   localparam int WDOG_W = 8;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   function automatic logic is_mem_op(input logic [6:0] opc);
      return (opc == OPC_LOAD) || (opc == OPC_STORE);
   endfunction

endpackage

// File: rtl/pipe_wdog.sv
// Data-memory watchdog: counts stalled cycles and flags when the last allowed
// cycle is reached. Saturates instead of wrapping.
module pipe_wdog
   import pipe_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64
) (
   input  logic clock,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   localparam logic [WDOG_W-1:0] LAST = WDOG_W'(MEM_TIMEOUT - 1);

   logic [WDOG_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (inc && (cnt_q != '1))
         cnt_d = cnt_q + WDOG_W'(1);
   end

   always_ff @(posedge clock) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign expired = (cnt_q == LAST);

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Five-stage pipeline sequencer: turns stall/redirect/memory handshakes into stage
// enables and valid bits. Optional performance counters under PIPE_PERF_CNT_EN.
module pipe_seq_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64
`ifdef PIPE_PERF_CNT_EN
   , parameter int CNT_W = 32
`endif
) (
   input  logic clock,
   input  logic reset,
   input  logic hazard_stall,
   input  logic redirect_e,
   input  logic imem_ready,
   input  logic dmem_req_m,
   input  logic dmem_ready,
   input  logic halt_w,
   output logic pc_en,
   output logic en_d,
   output logic en_e,
   output logic en_m,
   output logic en_w,
   output logic valid_d,
   output logic valid_e,
   output logic valid_m,
   output logic valid_w,
   output logic bubble_e,
   output logic flush_d,
   output logic halted,
   output logic bus_error
`ifdef PIPE_PERF_CNT_EN
   , output logic [CNT_W-1:0] cycle_cnt
   , output logic [CNT_W-1:0] instret_cnt
   , output logic [CNT_W-1:0] stall_cnt
`endif
);

   pipe_state_e state_q, state_d;
   logic valid_d_q, valid_d_d, valid_e_q, valid_e_d;
   logic valid_m_q, valid_m_d, valid_w_q, valid_w_d;
   logic halted_q, halted_d, bus_error_q, bus_error_d;
   logic mem_freeze, frozen, wdog_expired;

   assign mem_freeze = valid_m_q & dmem_req_m & ~dmem_ready;
   assign frozen     = reset || (state_q == HALT) || mem_freeze ||
                       ((state_q == MEM_WAIT) && !dmem_ready);

   // A completing access in MEM_WAIT lifts the freeze, so E is re-sampled that cycle.
   always_comb begin
      pc_en    = 1'b0;
      en_d     = 1'b0;
      en_e     = 1'b0;
      en_m     = 1'b0;
      en_w     = 1'b0;
      bubble_e = 1'b0;
      flush_d  = 1'b0;
      if (!frozen) begin
         if (redirect_e && valid_e_q) begin
            {pc_en, en_d, en_e, en_m, en_w} = 5'b11111;
            flush_d  = 1'b1;
            bubble_e = 1'b1;
         end else if (hazard_stall && valid_d_q) begin
            {en_e, en_m, en_w} = 3'b111;
            bubble_e = 1'b1;
         end else if (!imem_ready) begin
            {en_d, en_e, en_m, en_w} = 4'b1111;
            flush_d = 1'b1;
         end else begin
            {pc_en, en_d, en_e, en_m, en_w} = 5'b11111;
         end
      end
   end

   always_comb begin
      valid_d_d   = en_d ? (imem_ready & ~flush_d) : valid_d_q;
      valid_e_d   = en_e ? (valid_d_q & ~bubble_e) : valid_e_q;
      valid_m_d   = en_m ? valid_e_q : valid_m_q;
      valid_w_d   = en_w ? valid_m_q : valid_w_q;
      state_d     = state_q;
      bus_error_d = bus_error_q;
      unique case (state_q)
         RUN: begin
            if (mem_freeze)
               state_d = MEM_WAIT;
            else if (valid_w_q && halt_w)
               state_d = HALT;
         end
         MEM_WAIT: begin
            if (dmem_ready)
               state_d = (valid_w_q && halt_w) ? HALT : RUN;
            else if (wdog_expired) begin
               state_d     = HALT;
               bus_error_d = 1'b1;
            end
         end
         default: state_d = HALT;
      endcase
      halted_d = (state_d == HALT);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= RUN;
         valid_d_q   <= 1'b0;
         valid_e_q   <= 1'b0;
         valid_m_q   <= 1'b0;
         valid_w_q   <= 1'b0;
         halted_q    <= 1'b0;
         bus_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         valid_d_q   <= valid_d_d;
         valid_e_q   <= valid_e_d;
         valid_m_q   <= valid_m_d;
         valid_w_q   <= valid_w_d;
         halted_q    <= halted_d;
         bus_error_q <= bus_error_d;
      end
   end

   pipe_wdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wdog (
      .clock   (clock),
      .reset   (reset),
      .clr     (state_q == RUN),
      .inc     (state_q == MEM_WAIT),
      .expired (wdog_expired)
   );

   assign valid_d   = valid_d_q;
   assign valid_e   = valid_e_q;
   assign valid_m   = valid_m_q;
   assign valid_w   = valid_w_q;
   assign halted    = halted_q;
   assign bus_error = bus_error_q;

`ifdef PIPE_PERF_CNT_EN
   logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
   logic [CNT_W-1:0] instret_cnt_q, instret_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      cycle_cnt_d   = cycle_cnt_q;
      instret_cnt_d = instret_cnt_q;
      stall_cnt_d   = stall_cnt_q;
      if (state_q != HALT)
         cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
      if (valid_w_q && en_w)
         instret_cnt_d = instret_cnt_q + CNT_W'(1);
      if (!pc_en && (state_q != HALT))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cycle_cnt_q   <= '0;
         instret_cnt_q <= '0;
         stall_cnt_q   <= '0;
      end else begin
         cycle_cnt_q   <= cycle_cnt_d;
         instret_cnt_q <= instret_cnt_d;
         stall_cnt_q   <= stall_cnt_d;
      end
   end

   assign cycle_cnt   = cycle_cnt_q;
   assign instret_cnt = instret_cnt_q;
   assign stall_cnt   = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Randomized scoreboard bench for pipe_seq_ctrl: a pipeline-occupancy model predicts
// every cycle's controls, and a negedge monitor compares them against the DUT.
module tb_pipe_seq_ctrl;

   localparam int MEM_TIMEOUT = 4;
   localparam int CNT_W = 32;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic hazard_stall = 1'b0, redirect_e = 1'b0, imem_ready = 1'b0;
   logic dmem_req_m = 1'b0, dmem_ready = 1'b0, halt_w = 1'b0;
   logic pc_en, en_d, en_e, en_m, en_w;
   logic valid_d, valid_e, valid_m, valid_w;
   logic bubble_e, flush_d, halted, bus_error;
`ifdef PIPE_PERF_CNT_EN
   logic [CNT_W-1:0] cycle_cnt, instret_cnt, stall_cnt;
`endif

   pipe_seq_ctrl #(
      .MEM_TIMEOUT(MEM_TIMEOUT)
`ifdef PIPE_PERF_CNT_EN
      , .CNT_W(CNT_W)
`endif
   ) dut (
      .clock(clock), .reset(reset),
      .hazard_stall(hazard_stall), .redirect_e(redirect_e), .imem_ready(imem_ready),
      .dmem_req_m(dmem_req_m), .dmem_ready(dmem_ready), .halt_w(halt_w),
      .pc_en(pc_en), .en_d(en_d), .en_e(en_e), .en_m(en_m), .en_w(en_w),
      .valid_d(valid_d), .valid_e(valid_e), .valid_m(valid_m), .valid_w(valid_w),
      .bubble_e(bubble_e), .flush_d(flush_d), .halted(halted), .bus_error(bus_error)
`ifdef PIPE_PERF_CNT_EN
      , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt), .stall_cnt(stall_cnt)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [6:0]  ctl;
      logic [3:0]  vld;
      logic        hlt;
      logic        berr;
      logic [31:0] cyc;
      logic [31:0] ins;
      logic [31:0] stl;
   } exp_t;

   exp_t exp_q[$];
   int tests_run = 0;
   int tests_failed = 0;

   // Model: which stages hold a live instruction, and whether the core is running,
   // waiting on data memory, or stopped.
   int          m_mode = 0;
   bit [3:0]    m_pipe = '0;
   int          m_waited = 0;
   bit          m_halted = 1'b0;
   bit          m_berr = 1'b0;
   bit [31:0]   m_cyc = '0, m_ins = '0, m_stl = '0;

   task automatic applyStimulus(input bit rst, input bit hz, input bit rd, input bit im,
                                input bit dq, input bit dr, input bit hw);
      bit mem_stuck;
      bit pc, ed, ee, em, ew, bub, fl;
      bit [3:0] adv, inflow, nxt;
      exp_t e;
      reset = rst; hazard_stall = hz; redirect_e = rd; imem_ready = im;
      dmem_req_m = dq; dmem_ready = dr; halt_w = hw;

      mem_stuck = (m_mode == 1) ? !dr : (m_pipe[2] && dq && !dr);
      {pc, ed, ee, em, ew, bub, fl} = '0;
      if (!rst && m_mode != 2 && !mem_stuck) begin
         if (rd && m_pipe[1]) begin
            {pc, ed, ee, em, ew, bub, fl} = 7'b1111111;
         end else if (hz && m_pipe[0]) begin
            {ee, em, ew, bub} = 4'b1111;
         end else if (!im) begin
            {ed, ee, em, ew, fl} = 5'b11111;
         end else begin
            {pc, ed, ee, em, ew} = 5'b11111;
         end
      end
      e.ctl  = {pc, ed, ee, em, ew, bub, fl};
      e.vld  = {m_pipe[0], m_pipe[1], m_pipe[2], m_pipe[3]};
      e.hlt  = m_halted;
      e.berr = m_berr;
      e.cyc  = m_cyc;
      e.ins  = m_ins;
      e.stl  = m_stl;
      exp_q.push_back(e);

      if (rst) begin
         m_mode = 0; m_pipe = '0; m_waited = 0; m_halted = 0; m_berr = 0;
         m_cyc = '0; m_ins = '0; m_stl = '0;
      end else begin
         if (m_mode != 2) m_cyc++;
         if (m_mode != 2 && !pc) m_stl++;
         if (m_pipe[3] && ew) m_ins++;
         if (m_mode == 0) begin
            if (mem_stuck) begin
               m_mode = 1;
               m_waited = 0;
            end else if (m_pipe[3] && hw) begin
               m_mode = 2;
            end
         end else if (m_mode == 1) begin
            if (dr) begin
               m_mode = (m_pipe[3] && hw) ? 2 : 0;
            end else begin
               m_waited++;
               if (m_waited == MEM_TIMEOUT) begin
                  m_mode = 2;
                  m_berr = 1'b1;
               end
            end
         end
         m_halted = (m_mode == 2);
         adv    = {ew, em, ee, ed};
         inflow = {m_pipe[2], m_pipe[1], m_pipe[0] && !bub, im && !fl};
         nxt    = m_pipe;
         for (int s = 0; s < 4; s++)
            if (adv[s]) nxt[s] = inflow[s];
         m_pipe = nxt;
      end
   endtask

   task automatic checkOutput(input exp_t e);
      logic [6:0] act_ctl;
      logic [3:0] act_vld;
      act_ctl = {pc_en, en_d, en_e, en_m, en_w, bubble_e, flush_d};
      act_vld = {valid_d, valid_e, valid_m, valid_w};
      tests_run++;
      if (act_ctl !== e.ctl) begin
         tests_failed++;
         $display("[TB] FAIL controls @%0t: got %b expected %b", $time, act_ctl, e.ctl);
      end
      tests_run++;
      if (act_vld !== e.vld) begin
         tests_failed++;
         $display("[TB] FAIL valids @%0t: got %b expected %b", $time, act_vld, e.vld);
      end
      tests_run++;
      if (halted !== e.hlt) begin
         tests_failed++;
         $display("[TB] FAIL halted @%0t: got %b expected %b", $time, halted, e.hlt);
      end
      tests_run++;
      if (bus_error !== e.berr) begin
         tests_failed++;
         $display("[TB] FAIL bus_error @%0t: got %b expected %b", $time, bus_error, e.berr);
      end
`ifdef PIPE_PERF_CNT_EN
      tests_run++;
      if ({cycle_cnt, instret_cnt, stall_cnt} !== {e.cyc, e.ins, e.stl}) begin
         tests_failed++;
         $display("[TB] FAIL counters @%0t: got %0d/%0d/%0d expected %0d/%0d/%0d", $time,
                  cycle_cnt, instret_cnt, stall_cnt, e.cyc, e.ins, e.stl);
      end
`endif
   endtask

   always @(negedge clock) begin
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
   end

   initial begin
      int dq_pct, dr_pct;
      @(posedge clock); #1;
      for (int ep = 0; ep < 12; ep++) begin
         int rcyc;
         rcyc = 1 + int'($urandom_range(2));
         for (int i = 0; i < rcyc; i++) begin
            applyStimulus(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1,
                          1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
            @(posedge clock); #1;
         end
         case (ep % 3)
            0:       begin dq_pct = 30; dr_pct = 70; end
            1:       begin dq_pct = 70; dr_pct = 30; end
            default: begin dq_pct = 90; dr_pct = 5;  end
         endcase
         for (int i = 0; i < 80; i++) begin
            applyStimulus(1'b0,
                          ($urandom_range(99) < 20),
                          ($urandom_range(99) < 12),
                          ($urandom_range(99) < 80),
                          ($urandom_range(99) < dq_pct),
                          ($urandom_range(99) < dr_pct),
                          ($urandom_range(99) < 2));
            @(posedge clock); #1;
         end
      end
      @(negedge clock);
      @(negedge clock);
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
